// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file write port.
// req1 (load) has fixed priority; req0 (ALU) is guaranteed progress by an
// aging counter. The winning write goes through a one-cycle output stage
// that drives RW/WR/WD and the forwarding compare.
module regfile_wb_arbiter #(
  parameter int unsigned MAX_WAIT          = 3,
  parameter bit          ZERO_REG_WRITABLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rw,
  output logic [4:0]  wr,
  output logic [31:0] wd,
  input  logic [4:0]  rd_a,
  input  logic [4:0]  rd_b,
  output logic        fwd_a_hit,
  output logic        fwd_b_hit,
  output logic [31:0] fwd_data,
  output logic [3:0]  req0_wait
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]  r_wait;
  logic        r_rw;
  logic [4:0]  r_wr;
  logic [31:0] r_wd;

  logic        w_grant0;
  logic        w_grant1;
  logic [4:0]  w_acc_addr;
  logic [31:0] w_acc_data;
  logic        w_acc_write;

  // Arbitration: req1 wins unless req0 has aged to MAX_WAIT; nothing granted in reset
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || (r_wait >= LP_MAX_WAIT))) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  // Select the accepted transfer; writes to r0 complete the handshake but are dropped
  always_comb begin
    w_acc_addr  = w_grant0 ? req0_addr : req1_addr;
    w_acc_data  = w_grant0 ? req0_data : req1_data;
    w_acc_write = (w_grant0 || w_grant1) && (ZERO_REG_WRITABLE || (w_acc_addr != 5'd0));
  end

  // Aging counter: counts consecutive lost cycles of a pending req0, saturating at 15
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if (!req0_valid || w_grant0) begin
      r_wait <= '0;
    end else if (r_wait != 4'hF) begin
      r_wait <= r_wait + 4'd1;
    end
  end

  // Output stage: one-cycle registered write; WR/WD hold when nothing is written
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw <= 1'b0;
      r_wr <= '0;
      r_wd <= '0;
    end else begin
      r_rw <= w_acc_write;
      if (w_acc_write) begin
        r_wr <= w_acc_addr;
        r_wd <= w_acc_data;
      end
    end
  end

  // Outputs and forwarding compare against the in-flight write
  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    rw         = r_rw;
    wr         = r_wr;
    wd         = r_wd;
    fwd_data   = r_wd;
    fwd_a_hit  = r_rw && (r_wr == rd_a);
    fwd_b_hit  = r_rw && (r_wr == rd_b);
    req0_wait  = r_wait;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32-bit CPU register file between two writeback sources: req0 = ALU writeback, req1 = memory-load writeback.
- Fixed priority to req1, with an aging counter that guarantees req0 progress.
- Registers the winning write into a one-cycle output stage that drives the register file's RW/WR/WD.
- Provides forwarding hits for the two read addresses against the in-flight write.

Parameters:
- MAX_WAIT, 3: consecutive cycles req0 may lose arbitration before it is forced to win (legal range 1..15).
- ZERO_REG_WRITABLE, 0: 0 = writes to address 0 are accepted but discarded; 1 = written normally.

Ports:
- clk  in  1  rising-edge clock, shared with the register file
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  ALU write request
- req0_addr  in  5  ALU destination register
- req0_data  in  32  ALU write data
- req0_ready  out  1  req0 accepted this cycle
- req1_valid  in  1  load write request
- req1_addr  in  5  load destination register
- req1_data  in  32  load write data
- req1_ready  out  1  req1 accepted this cycle
- rw  out  1  register-file write enable
- wr  out  5  register-file write address
- wd  out  32  register-file write data
- rd_a  in  5  register-file read address A (mirrors RD1 address)
- rd_b  in  5  register-file read address B (mirrors RD2 address)
- fwd_a_hit  out  1  in-flight write targets rd_a
- fwd_b_hit  out  1  in-flight write targets rd_b
- fwd_data  out  32  in-flight write data (equals wd)
- req0_wait  out  4  current req0 aging count (debug)

Behaviour:
- Reset (rst high at a clk edge):
  - rw=0, wr=0, wd=0, req0_wait=0.
  - req0_ready=0 and req1_ready=0 combinationally while rst=1.
  - An in-flight output-stage write is dropped: rw is 0 in the cycle after reset asserts.
- Handshake:
  - readyN is combinational from the valid inputs and req0_wait.
  - A transfer occurs when validN && readyN at a rising edge.
  - Requesters hold addr/data stable until accepted.
  - At most one ready is high per cycle.
- Arbitration, per cycle:
  - Only req0 valid -> req0_ready=1.
  - Only req1 valid -> req1_ready=1.
  - Both valid and req0_wait < MAX_WAIT -> req1 wins.
  - Both valid and req0_wait >= MAX_WAIT -> req0 wins.
  - Neither valid -> both ready=0.
- Aging counter:
  - req0_wait increments by 1 on every edge where req0_valid=1 and req0 is not accepted; it saturates at 15.
  - It clears to 0 on a req0 acceptance, or when req0_valid=0.
- Output stage, one cycle latency:
  - The accepted transfer at edge N drives rw=1, wr=addr, wd=data during cycle N..N+1; the register file commits at edge N+1.
  - With no acceptance at edge N, rw=0 the following cycle; wr/wd hold their previous values.
  - Back-to-back acceptances produce consecutive single-cycle rw pulses with no bubble.
- Zero register (ZERO_REG_WRITABLE=0):
  - An accepted transfer with addr=0 completes the handshake (ready=1) but leaves rw=0 the next cycle.
  - wr/wd are not updated for it.
- Forwarding:
  - fwd_a_hit = rw && (wr == rd_a); fwd_b_hit = rw && (wr == rd_b). Both are combinational.
  - fwd_data = wd.
  - Consumers select fwd_data over the register-file read during the cycle before commit.
  - rd_a == rd_b == wr with rw=1 -> both hits are 1.
- Same-address collisions:
  - Both requesters targeting the same address is legal. The writes are serialized in grant order, and the last committed write persists.

Test Plan:
- Reset check: assert rst with req1_valid=1, addr=5, data=0xDEADBEEF -> req1_ready=0, rw=0, wr=0, wd=0, req0_wait=0; after deassert, req1 is accepted and rw=1, wr=5, wd=0xDEADBEEF one cycle later.
- Aging, MAX_WAIT=3: hold req0 (addr=2, data=0x11) and req1 (addrs 3,4,5,6, data 0x20+k) valid continuously.
  - Grants: req1, req1, req1, then req0 on the 4th cycle.
  - rw pulses on wr=3,4,5,2 in consecutive cycles; req0_wait sequence 0,1,2,3,0.
- Zero-register discard: req0 addr=0, data=0xFFFFFFFF -> req0_ready=1; rw=0 next cycle; fwd_a_hit=0 with rd_a=0; wr/wd unchanged.
- Forwarding: accept req0 addr=7, data=0x12345678, then set rd_a=7, rd_b=7 in the rw cycle -> fwd_a_hit=fwd_b_hit=1, fwd_data=0x12345678. The next cycle with no request -> both hits 0.
- Reset mid-operation: accept req1 addr=9, then assert rst in the same cycle that rw=1 -> after the edge rw=0 and register 9 receives no further write; the output stage is cleared.
- Idle and single-source streaming: only req0 valid for 5 cycles with addrs 1..5 -> 5 back-to-back rw pulses, req0_wait stays 0, req1_ready stays 0.
